// File: rtl/cov_pkg.sv
// cov_pkg -- shared parameters and FSM state type for the covariance
// accumulation stage (cov_accum and its cov_acc_lane instances).
//
// Build option: define COV_ACC_ROUND_EN to round half-up before the final
// divide-by-N; leave it undefined for a plain arithmetic shift (floor).
package cov_pkg;

  localparam int N_SAMPLES = 128;            // samples per block, power of two
  localparam int LOG2_N    = 7;              // log2(N_SAMPLES)
  localparam int PROD_W    = 52;             // product / covariance width
  localparam int ACC_W     = PROD_W + LOG2_N; // room for N worst-case products
  localparam int N_LANES   = 10;             // upper triangle of a 4x4 matrix

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/cov_acc_lane.sv
// cov_acc_lane -- one covariance lane: signed accumulator, divide-by-N
// (arithmetic shift, optional round half-up) and the output register.
//
// Build option: COV_ACC_ROUND_EN adds 2^(LOG2_N-1) to the final sum,
// computed in ACC_W+1 bits, before the shift.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr    in   force the accumulator to zero (idle or aborted block)
//   add    in   accumulate prod this cycle
//   last   in   this prod completes the block: publish result, restart sum
//   prod   in   PROD_W signed product
//   cov    out  PROD_W signed covariance, held until the next block ends
module cov_acc_lane
  import cov_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     add,
  input  logic                     last,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [PROD_W-1:0] cov
);

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [PROD_W-1:0] cov_q;
  logic signed [PROD_W-1:0] cov_d;

`ifdef COV_ACC_ROUND_EN
  // Half of N, i.e. 2^(LOG2_N-1), in ACC_W+1 bits.
  localparam logic signed [ACC_W:0] RND_BIAS =
    {{(ACC_W+1-LOG2_N){1'b0}}, 1'b1, {(LOG2_N-1){1'b0}}};
  logic signed [ACC_W:0] sum_rnd;
`endif

  always_comb begin
    prod_ext = {{LOG2_N{prod[PROD_W-1]}}, prod};
    sum      = acc_q + prod_ext;

    acc_d = acc_q;
    if (clr || last) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = sum;
    end
  end

  always_comb begin
    cov_d = cov_q;
`ifdef COV_ACC_ROUND_EN
    // One extra bit so the bias can never wrap the largest sum.
    sum_rnd = {sum[ACC_W-1], sum} + RND_BIAS;
    if (last) begin
      cov_d = PROD_W'(sum_rnd >>> LOG2_N);
    end
`else
    if (last) begin
      cov_d = PROD_W'(sum >>> LOG2_N);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cov_q <= '0;
    end else begin
      acc_q <= acc_d;
      cov_q <= cov_d;
    end
  end

  assign cov = cov_q;

endmodule

// File: rtl/cov_accum.sv
// cov_accum -- covariance accumulation stage of the whitening path.
// Sums the ten pairwise products of each sample over blocks of N_SAMPLES,
// divides by N and presents the ten covariance entries with a one-cycle
// cov_valid pulse. Blocks run back to back; bubbles (in_valid=0) are
// allowed anywhere; dropping en aborts the current block.
//
// Build option: COV_ACC_ROUND_EN selects round half-up in every lane
// (see cov_acc_lane); undefined gives floor.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   en                   block enable; low aborts and returns to IDLE
//   in_valid             product set valid this cycle
//   x1x1 .. x4x4         PROD_W signed pairwise products
//   c11 .. c44           PROD_W signed covariance entries
//   cov_valid            one-cycle pulse, c** new this cycle
//   busy                 a block is partially accumulated
module cov_accum
  import cov_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic signed [PROD_W-1:0] x1x1,
  input  logic signed [PROD_W-1:0] x1x2,
  input  logic signed [PROD_W-1:0] x1x3,
  input  logic signed [PROD_W-1:0] x1x4,
  input  logic signed [PROD_W-1:0] x2x2,
  input  logic signed [PROD_W-1:0] x2x3,
  input  logic signed [PROD_W-1:0] x2x4,
  input  logic signed [PROD_W-1:0] x3x3,
  input  logic signed [PROD_W-1:0] x3x4,
  input  logic signed [PROD_W-1:0] x4x4,
  output logic signed [PROD_W-1:0] c11,
  output logic signed [PROD_W-1:0] c12,
  output logic signed [PROD_W-1:0] c13,
  output logic signed [PROD_W-1:0] c14,
  output logic signed [PROD_W-1:0] c22,
  output logic signed [PROD_W-1:0] c23,
  output logic signed [PROD_W-1:0] c24,
  output logic signed [PROD_W-1:0] c33,
  output logic signed [PROD_W-1:0] c34,
  output logic signed [PROD_W-1:0] c44,
  output logic                     cov_valid,
  output logic                     busy
);

  localparam logic [LOG2_N-1:0] LAST_CNT = LOG2_N'(N_SAMPLES - 1);

  state_e            state_q;
  state_e            state_d;
  logic [LOG2_N-1:0] count_q;
  logic [LOG2_N-1:0] count_d;
  logic              cov_valid_q;
  logic              cov_valid_d;
  logic              busy_q;
  logic              busy_d;

  logic clr;
  logic add;
  logic last;

  logic signed [PROD_W-1:0] prod_arr [N_LANES];
  logic signed [PROD_W-1:0] cov_arr  [N_LANES];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = ACCUM;
      ACCUM:   if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Anything other than "ACCUM with en high" clears the lanes, which both
  // holds them at zero in IDLE and discards a partial block on abort.
  always_comb begin
    clr  = 1'b1;
    add  = 1'b0;
    last = 1'b0;
    case (state_q)
      ACCUM: begin
        if (en) begin
          clr  = 1'b0;
          add  = in_valid;
          last = in_valid && (count_q == LAST_CNT);
        end
      end
      default: ;
    endcase
  end

  // ---------------- sample counter, cov_valid, busy ----------------
  always_comb begin
    count_d = count_q;
    if (clr || last) begin
      count_d = '0;
    end else if (add) begin
      count_d = count_q + 1'b1;
    end
    cov_valid_d = last;
    busy_d      = (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      cov_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      cov_valid_q <= cov_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cov_valid = cov_valid_q;
  assign busy      = busy_q;

  // ---------------- lanes ----------------
  assign prod_arr[0] = x1x1;
  assign prod_arr[1] = x1x2;
  assign prod_arr[2] = x1x3;
  assign prod_arr[3] = x1x4;
  assign prod_arr[4] = x2x2;
  assign prod_arr[5] = x2x3;
  assign prod_arr[6] = x2x4;
  assign prod_arr[7] = x3x3;
  assign prod_arr[8] = x3x4;
  assign prod_arr[9] = x4x4;

  generate
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      cov_acc_lane u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .add   (add),
        .last  (last),
        .prod  (prod_arr[gi]),
        .cov   (cov_arr[gi])
      );
    end
  endgenerate

  assign c11 = cov_arr[0];
  assign c12 = cov_arr[1];
  assign c13 = cov_arr[2];
  assign c14 = cov_arr[3];
  assign c22 = cov_arr[4];
  assign c23 = cov_arr[5];
  assign c24 = cov_arr[6];
  assign c33 = cov_arr[7];
  assign c34 = cov_arr[8];
  assign c44 = cov_arr[9];

endmodule
